// File: rtl/timer_pkg.sv
// Shared definitions for the FF04-FF07 divider/timer block: register indices,
// sequencer states and the TAC tap positions within the M-cycle divider.
package timer_pkg;

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_OVF = 2'd1,
    ST_RLD = 2'd2
  } state_t;

  // Divider bit watched for each TAC[1:0] frequency select.
  localparam int TAP_SEL0 = 7;  // 4096 Hz
  localparam int TAP_SEL1 = 1;  // 262144 Hz
  localparam int TAP_SEL2 = 3;  // 65536 Hz
  localparam int TAP_SEL3 = 5;  // 16384 Hz

endpackage

// File: rtl/timer_edge.sv
// Selects the TAC-enabled divider tap and flags its falling edge. Any cause of
// a 1->0 transition (count, DIV clear, TAC change) produces a tick.
module timer_edge
  import timer_pkg::*;
#(
  parameter int DIV_W = 14
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [DIV_W-1:0] div_next,
  input  logic [2:0]       tac,
  output logic             tick
);

  logic sel_bit;
  logic tap_d;
  logic tap_q;

  always_comb begin
    case (tac[1:0])
      2'b00:   sel_bit = div_next[TAP_SEL0];
      2'b01:   sel_bit = div_next[TAP_SEL1];
      2'b10:   sel_bit = div_next[TAP_SEL2];
      default: sel_bit = div_next[TAP_SEL3];
    endcase
    tap_d = tac[2] & sel_bit;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tap_q <= 1'b0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign tick = tap_q & ~tap_d;

endmodule

// File: rtl/timer_ctrl.sv
// Divider/timer sequencer: free-running divider, TIMA count with the
// overflow -> reload sequence, timer interrupt pulse and CPU register window.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DIV_W   = 14,
  parameter int APU_TAP = 10
) (
  input  logic             boga1mhz,
  input  logic             reset,
  input  logic             ff04_ff07,
  input  logic [1:0]       addr,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             dout_oe,
  output logic             irq_timer,
  output logic [DIV_W-1:0] div_bits,
  output logic             apu_div_bit
);

  logic [DIV_W-1:0] div_d, div_q;
  logic [7:0]       tima_d, tima_q;
  logic [7:0]       tma_d, tma_q;
  logic [2:0]       tac_d, tac_q;
  logic             irq_d, irq_q;
  state_t           state_d, state_q;

  logic wr_en, wr_div, wr_tima, wr_tma, wr_tac;
  logic tick;

  assign wr_en   = ff04_ff07 & cpu_wr;
  assign wr_div  = wr_en & (addr == REG_DIV);
  assign wr_tima = wr_en & (addr == REG_TIMA);
  assign wr_tma  = wr_en & (addr == REG_TMA);
  assign wr_tac  = wr_en & (addr == REG_TAC);

  always_comb begin
    div_d = wr_div ? '0 : div_q + DIV_W'(1);
    tma_d = wr_tma ? din : tma_q;
    tac_d = wr_tac ? din[2:0] : tac_q;
  end

  // Edge detector sees the post-write divider and TAC, so clears and TAC
  // writes can tick in the very cycle they happen.
  timer_edge #(.DIV_W(DIV_W)) u_edge (
    .clk      (boga1mhz),
    .srst     (reset),
    .div_next (div_d),
    .tac      (tac_d),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    irq_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wr_tima) begin
          tima_d = din;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      ST_OVF: begin
        if (wr_tima) begin
          tima_d  = din;
          state_d = ST_RUN;
        end else begin
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = ST_RLD;
        end
      end
      ST_RLD: begin
        state_d = ST_RUN;
        if (wr_tma) begin
          tima_d = din;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge boga1mhz) begin
    if (reset) begin
      div_q   <= '0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      irq_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      div_q   <= div_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      irq_q   <= irq_d;
      state_q <= state_d;
    end
  end

  assign dout_oe = ff04_ff07 & cpu_rd;

  always_comb begin
    dout = 8'h00;
    if (dout_oe) begin
      case (addr)
        REG_DIV:  dout = div_q[DIV_W-1 -: 8];
        REG_TIMA: dout = tima_q;
        REG_TMA:  dout = tma_q;
        default:  dout = {5'b11111, tac_q};
      endcase
    end
  end

  assign irq_timer   = irq_q;
  assign div_bits    = div_q;
  assign apu_div_bit = div_q[APU_TAP];

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the timer rules.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ff04_ff07;
  logic [1:0]  addr;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        irq_timer;
  logic [13:0] div_bits;
  logic        apu_div_bit;

  timer_ctrl #(.DIV_W(14), .APU_TAP(10)) dut (
    .boga1mhz    (clk),
    .reset       (reset),
    .ff04_ff07   (ff04_ff07),
    .addr        (addr),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .din         (din),
    .dout        (dout),
    .dout_oe     (dout_oe),
    .irq_timer   (irq_timer),
    .div_bits    (div_bits),
    .apu_div_bit (apu_div_bit)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integers, phase 0=counting 1=overflowed 2=reloaded
  int m_div, m_tima, m_tma, m_tac, m_phase, m_prev_tap, m_irq;
  logic       rst_req;
  logic [7:0] last_dout;
  logic       last_irq;
  logic       last_apu;
  logic [13:0] last_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
    m_phase = 0; m_prev_tap = 0; m_irq = 0;
  endfunction

  function automatic int exp_dout(input int a);
    case (a)
      0:       return (m_div / 64) % 256;
      1:       return m_tima;
      2:       return m_tma;
      default: return 248 + m_tac;
    endcase
  endfunction

  function automatic void model_step(input bit s, input bit w, input int a, input int d);
    bit wr;
    int ndiv, ntac, ntma, ntima, nphase, nirq, tap, tick, bitpos;
    int taps[4] = '{7, 1, 3, 5};
    wr     = s && w;
    ndiv   = (wr && a == 0) ? 0 : (m_div + 1) % 16384;
    ntac   = (wr && a == 3) ? (d % 8) : m_tac;
    ntma   = (wr && a == 2) ? d : m_tma;
    bitpos = taps[ntac % 4];
    tap    = (ntac >= 4) ? ((ndiv >> bitpos) % 2) : 0;
    tick   = (m_prev_tap == 1 && tap == 0) ? 1 : 0;
    ntima  = m_tima;
    nphase = 0;
    nirq   = 0;
    if (m_phase == 1) begin
      if (wr && a == 1) ntima = d;
      else begin ntima = ntma; nirq = 1; nphase = 2; end
    end else begin
      if (m_phase == 0 && wr && a == 1) ntima = d;
      else if (m_phase == 2 && wr && a == 2) ntima = d;
      else if (tick == 1) begin
        if (m_tima == 255) begin ntima = 0; nphase = 1; end
        else ntima = m_tima + 1;
      end
    end
    m_div = ndiv; m_tac = ntac; m_tma = ntma; m_tima = ntima;
    m_phase = nphase; m_irq = nirq; m_prev_tap = tap;
  endfunction

  task automatic step(input bit s, input bit w, input bit r, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    reset = rst_req; ff04_ff07 = s; cpu_wr = w; cpu_rd = r; addr = a; din = d;
    #1;
    chk("dout_oe", {31'd0, dout_oe}, {31'd0, s & r});
    if (s && r) chk("dout", {24'd0, dout}, exp_dout(int'(a)));
    chk("irq", {31'd0, irq_timer}, m_irq);
    chk("div", {18'd0, div_bits}, m_div);
    chk("apu", {31'd0, apu_div_bit}, (m_div >> 10) % 2);
    last_dout = dout; last_irq = irq_timer; last_apu = apu_div_bit; last_div = div_bits;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(s, w, int'(a), int'(d));
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic wait_phase(input int target, input string tag);
    for (int i = 0; i < 64 && m_phase != target; i++) rd(2'd1);
    if (m_phase != target) begin
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=phase%0d", tag, target);
    end
  endtask

  initial begin
    int v, last_toggle, wraps;
    bit prev_zero, done, prev_apu;
    rst_req = 1'b1; reset = 1'b1;
    ff04_ff07 = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; addr = 2'd0; din = 8'h00;
    repeat (2) @(posedge clk);
    model_reset();

    // 1: idle after reset, DIV read at cycle 256
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    rst_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rd(2'd0);
      if (i == 256) chk("t1_div256", {24'd0, last_dout}, 32'h04);
    end
    rd(2'd1);
    chk("t1_tima_idle", {24'd0, last_dout}, 32'h00);

    // 2: fast tap overflow and reload
    wr(2'd3, 8'h05); wr(2'd2, 8'hF0); wr(2'd1, 8'hFE);
    prev_zero = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      rd(2'd1);
      if (prev_zero) begin
        chk("t2_reload", {24'd0, last_dout}, 32'hF0);
        chk("t2_irq", {31'd0, last_irq}, 32'h1);
        done = 1'b1;
      end
      prev_zero = (last_dout == 8'h00);
    end
    if (!done) chk("t2_reload_seen", 32'(done), 32'h1);

    // 3: TIMA write in OVF cancels reload; in RLD it is ignored
    wr(2'd1, 8'hFE);
    wait_phase(1, "t3_wait_ovf");
    wr(2'd1, 8'h33);
    rd(2'd1);
    chk("t3_ovf_write", {24'd0, last_dout}, 32'h33);
    chk("t3_ovf_noirq", {31'd0, last_irq}, 32'h0);
    wr(2'd1, 8'hFE);
    wait_phase(2, "t3_wait_rld");
    wr(2'd1, 8'h33);
    chk("t3_rld_irq", {31'd0, last_irq}, 32'h1);
    rd(2'd1);
    chk("t3_rld_write", {24'd0, last_dout}, 32'hF0);

    // 4: glitch ticks from DIV clear and TAC change
    wr(2'd1, 8'h10);
    for (int i = 0; i < 8 && (m_div / 2) % 2 == 0; i++) rd(2'd1);
    v = m_tima;
    wr(2'd0, 8'h5A);
    rd(2'd1);
    chk("t4_div_tick", {24'd0, last_dout}, v + 1);
    chk("t4_div_clear", {18'd0, last_div}, 32'h0);
    for (int i = 0; i < 8 && m_div % 4 != 2; i++) rd(2'd1);
    v = m_tima;
    wr(2'd3, 8'h04);
    rd(2'd1);
    chk("t4_tac_tick", {24'd0, last_dout}, v + 1);

    // 5: TMA write during RLD, then reset during OVF
    wr(2'd2, 8'hF0); wr(2'd1, 8'hFE); wr(2'd3, 8'h05);
    wait_phase(2, "t5_wait_rld");
    wr(2'd2, 8'h80);
    rd(2'd1);
    chk("t5_tma_rld", {24'd0, last_dout}, 32'h80);
    wr(2'd1, 8'hFE);
    wait_phase(1, "t5_wait_ovf");
    rst_req = 1'b1;
    rd(2'd1);
    rst_req = 1'b0;
    rd(2'd1);
    chk("t5_rst_tima", {24'd0, last_dout}, 32'h00);
    chk("t5_rst_irq", {31'd0, last_irq}, 32'h0);
    chk("t5_rst_div", {18'd0, last_div}, 32'h0);
    rd(2'd3);
    chk("t5_rst_tac", {24'd0, last_dout}, 32'hF8);
    rd(2'd2);
    chk("t5_rst_tma", {24'd0, last_dout}, 32'h00);

    // Random traffic with sparse writes
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 2) == 1,
           2'($urandom), 8'($urandom));
    end

    // 6: free-run one full divider period without writes
    wraps = 0; last_toggle = -1; prev_apu = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      step(($urandom % 2) == 1, 1'b0, ($urandom % 2) == 1, 2'($urandom), 8'h00);
      if (last_div == 14'd0) wraps++;
      if (i > 0 && last_apu != prev_apu) begin
        if (last_toggle >= 0) chk("t6_apu_period", i - last_toggle, 32'd1024);
        last_toggle = i;
      end
      prev_apu = last_apu;
    end
    chk("t6_div_wrap", wraps, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
